mazesolver_soc_sysid_checker: RTL and testbench
===============================================

// Module: mazesolver_soc_sysid_checker
// PURPOSE
//  Boot-time sequencer that reads the system-ID slave over Avalon-MM and checks
//  the ID word (addr 0) and build timestamp (addr 1) against expected values.
//  Holds the Nios II CPU in reset until both words match; flags mismatch or timeout.
//  Sits between the reset controller and the CPU reset input in mazesolver_soc.
// PARAMETERS
//  EXPECTED_ID      32'h0000_0000  required word at address 0
//  EXPECTED_TS      32'd1448544260 required word at address 1
//  TIMEOUT_CYCLES   256            max cycles avm_waitrequest may stay high per read
//  MAX_RETRIES      3              timed-out reads retried before ERROR (0..15)
// PORTS
//  clock            in   1   system clock
//  reset_n          in   1   asynchronous active-low reset
//  recheck          in   1   1-cycle pulse: rerun check sequence (honoured in DONE/ERROR only)
//  avm_address      out  1   0 = ID word, 1 = timestamp word
//  avm_read         out  1   Avalon read request
//  avm_readdata     in   32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0
//  avm_waitrequest  in   1   slave stall
//  cpu_reset_req    out  1   1 = hold CPU in reset
//  check_done       out  1   sequence finished (pass or fail)
//  id_ok            out  1   ID word matched
//  ts_ok            out  1   timestamp matched
//  timeout_err      out  1   retries exhausted on a stalled read
//  id_value         out  32  captured ID word
//  ts_value         out  32  captured timestamp word
// BEHAVIOUR
//  Reset (async on reset_n low): state=RD_ID, avm_read=0, avm_address=0,
//   cpu_reset_req=1, check_done=0, id_ok=0, ts_ok=0, timeout_err=0,
//   id_value=0, ts_value=0, timeout/retry counters=0. Reset mid-sequence aborts the
//   read; first read issued on the first clock edge after reset_n deasserts.
//  States: RD_ID -> RD_TS -> CMP -> DONE; ERROR on mismatch or timeout.
//  RD_ID: avm_read=1, avm_address=0. Accept cycle (avm_waitrequest=0): capture
//   id_value, drop avm_read for one cycle (gap), go RD_TS.
//  RD_TS: same with avm_address=1; capture ts_value, go CMP.
//  avm_address/avm_read held stable while avm_waitrequest=1 (Avalon rule).
//  Timeout: counter increments each stalled cycle; at TIMEOUT_CYCLES-1 stalled
//   cycles the read is abandoned (avm_read=0 one cycle), retry count++ and the same
//   read is reissued. After MAX_RETRIES retries also time out -> ERROR, timeout_err=1.
//   Counter clears on every accepted read and on state change.
//  CMP (1 cycle): id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS)
//   registered; both 1 -> DONE, else ERROR.
//  DONE: check_done=1, cpu_reset_req=0 (released the cycle after CMP).
//  ERROR: check_done=1, cpu_reset_req stays 1; id_ok/ts_ok show which word failed.
//  recheck in DONE/ERROR: cpu_reset_req=1, check_done/id_ok/ts_ok/timeout_err=0,
//   retry count=0, go RD_ID next cycle. recheck in any other state ignored.
//  Latency, zero-wait slave: release on cycle 6 after reset (RD_ID, gap, RD_TS, CMP, DONE).
//  Equality is full 32-bit unsigned; no masking.
// TESTING
//  1 zero-wait slave returns 0 then 1448544260 -> id_ok=ts_ok=1, cpu_reset_req=0
//    within 6 cycles of reset release, avm_read drops for 1 cycle between reads.
//  2 timestamp returns 1448544261 -> ERROR: check_done=1, id_ok=1, ts_ok=0,
//    cpu_reset_req=1; recheck with correct data -> DONE, cpu_reset_req=0.
//  3 waitrequest stuck high on addr 0 -> 4 read attempts (1+3 retries) of 256 cycles,
//    then timeout_err=1, cpu_reset_req=1, avm_read=0.
//  4 waitrequest high 255 cycles then low with data -> accepted, no retry,
//    avm_address/avm_read stable throughout stall.
//  5 reset_n pulsed low mid RD_TS stall -> outputs return to reset values
//    immediately; sequence restarts at address 0.
//  6 recheck pulsed during RD_TS -> ignored; sequence completes unchanged.

Source files
------------

// File: rtl/mazesolver_soc_sysid_checker.sv
// Purpose : boot-time system-ID check. Reads the ID word (addr 0) and the build
//           timestamp (addr 1) over Avalon-MM and holds the CPU in reset until both match.
// Latency : with a zero-wait slave, cpu_reset_req drops on the 5th clock edge after reset release.
// Backpr. : obeys avm_waitrequest and holds address/read stable while stalled. A read
//           stalled TIMEOUT_CYCLES cycles is abandoned and reissued, up to MAX_RETRIES times.
// Ports   : clock, reset_n, recheck pulse; Avalon-MM master (avm_*); cpu_reset_req,
//           check_done, id_ok, ts_ok, timeout_err, plus the captured id_value/ts_value words.
module mazesolver_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1448544260,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        recheck,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        cpu_reset_req,
    output logic        check_done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [2:0] ST_RD_ID = 3'd0;
    localparam logic [2:0] ST_RD_TS = 3'd1;
    localparam logic [2:0] ST_CMP   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    logic [2:0]    state_q, state_d;
    logic          read_q, read_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          rst_req_q, rst_req_d;
    logic          done_q, done_d;
    logic          id_ok_q, id_ok_d;
    logic          ts_ok_q, ts_ok_d;
    logic          tmo_q, tmo_d;
    logic [31:0]   id_val_q, id_val_d;
    logic [31:0]   ts_val_q, ts_val_d;

    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        to_cnt_d  = to_cnt_q;
        retry_d   = retry_q;
        rst_req_d = rst_req_q;
        done_d    = done_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        tmo_d     = tmo_q;
        id_val_d  = id_val_q;
        ts_val_d  = ts_val_q;

        case (state_q)
            ST_RD_ID, ST_RD_TS: begin
                if (!read_q) begin
                    // Entry, post-accept gap or post-abandon gap: (re)issue the read.
                    read_d = 1'b1;
                end else if (!avm_waitrequest) begin
                    read_d   = 1'b0;
                    to_cnt_d = '0;
                    // The retry budget applies to each word independently.
                    retry_d  = '0;
                    if (state_q == ST_RD_ID) begin
                        id_val_d = avm_readdata;
                        state_d  = ST_RD_TS;
                    end else begin
                        ts_val_d = avm_readdata;
                        state_d  = ST_CMP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // The stall budget is exhausted, so drop the request for one cycle.
                    read_d   = 1'b0;
                    to_cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_ERROR;
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        retry_d = retry_q + 4'd1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_CMP: begin
                id_ok_d = (id_val_q == EXPECTED_ID);
                ts_ok_d = (ts_val_q == EXPECTED_TS);
                done_d  = 1'b1;
                if ((id_val_q == EXPECTED_ID) && (ts_val_q == EXPECTED_TS)) begin
                    state_d   = ST_DONE;
                    rst_req_d = 1'b0;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (recheck) begin
                    state_d   = ST_RD_ID;
                    rst_req_d = 1'b1;
                    done_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    tmo_d     = 1'b0;
                    retry_d   = '0;
                    to_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_RD_ID;
                read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RD_ID;
            read_q    <= 1'b0;
            to_cnt_q  <= '0;
            retry_q   <= '0;
            rst_req_q <= 1'b1;
            done_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            tmo_q     <= 1'b0;
            id_val_q  <= '0;
            ts_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
            rst_req_q <= rst_req_d;
            done_q    <= done_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            tmo_q     <= tmo_d;
            id_val_q  <= id_val_d;
            ts_val_q  <= ts_val_d;
        end
    end

    // The address follows the state, so it cannot move while a read is stalled.
    assign avm_address   = (state_q == ST_RD_TS);
    assign avm_read      = read_q;
    assign cpu_reset_req = rst_req_q;
    assign check_done    = done_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign timeout_err   = tmo_q;
    assign id_value      = id_val_q;
    assign ts_value      = ts_val_q;

endmodule

// File: tb/tb_mazesolver_soc_sysid_checker.sv
module tb_mazesolver_soc_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1448544260;
    localparam int          BIG    = 100000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        recheck = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        cpu_reset_req;
    logic        check_done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    mazesolver_soc_sysid_checker dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .recheck        (recheck),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .cpu_reset_req  (cpu_reset_req),
        .check_done     (check_done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout_err    (timeout_err),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic        rst_req;
        logic        tmo;
    } res_t;

    res_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Avalon slave model state
    logic [31:0] slv_data [2];
    int          slv_stall [2];
    int          stall_cnt, attempts, drops, unstable, cur_len;
    logic        first_addr, prev_read, prev_addr, prev_wait;
    int          len_q[$];
    logic        rd_hist[$];
    logic        rq_hist[$];

    function automatic res_t model(input logic [31:0] d0, input logic [31:0] d1);
        res_t r;
        r.id      = d0;
        r.ts      = d1;
        r.id_ok   = (d0 == EXP_ID);
        r.ts_ok   = (d1 == EXP_TS);
        r.rst_req = !((d0 == EXP_ID) && (d1 == EXP_TS));
        r.tmo     = 1'b0;
        return r;
    endfunction

    function automatic res_t observed();
        return {id_value, ts_value, id_ok, ts_ok, cpu_reset_req, timeout_err};
    endfunction

    task automatic slave_init(input logic [31:0] d0, input logic [31:0] d1,
                              input int s0, input int s1);
        slv_data[0] = d0;  slv_data[1] = d1;
        slv_stall[0] = s0; slv_stall[1] = s1;
        stall_cnt = 0; attempts = 0; drops = 0; unstable = 0; cur_len = 0;
        first_addr = 1'b1; prev_read = 1'b0; prev_addr = 1'b0; prev_wait = 1'b0;
        len_q.delete(); rd_hist.delete(); rq_hist.delete();
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
    endtask

    // One clock of the slave: observe DUT at the falling edge, drive the response
    // that the next rising edge will sample.
    task automatic slave_cycle();
        @(negedge clock);
        rd_hist.push_back(avm_read);
        rq_hist.push_back(cpu_reset_req);
        if (avm_read) begin
            if (!prev_read) begin
                if (attempts == 0) first_addr = avm_address;
                attempts++;
                stall_cnt = 0;
                cur_len = 0;
            end else if (prev_wait && (avm_address !== prev_addr)) begin
                unstable++;
            end
            cur_len++;
            if (stall_cnt < slv_stall[avm_address]) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = slv_data[avm_address];
            end
        end else begin
            if (prev_read) begin
                len_q.push_back(cur_len);
                if (prev_wait) drops++;
            end
            avm_waitrequest = 1'b0;
        end
        prev_read = avm_read;
        prev_addr = avm_address;
        prev_wait = avm_waitrequest;
    endtask

    task automatic run_until_done(input int budget, output int n, output bit expired);
        n = 0;
        expired = 1'b1;
        for (int i = 0; i < budget; i++) begin
            slave_cycle();
            n++;
            if (check_done === 1'b1) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0]  flags;
        logic [63:0] words;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        flags = {avm_read, avm_address, cpu_reset_req, check_done, id_ok, ts_ok, timeout_err};
        words = {id_value, ts_value};
        vectors++;
        if (flags !== 7'b0010000) begin
            miscompares++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0010000);
        end
        vectors++;
        if (words !== 64'h0) begin
            miscompares++; $display("FAIL reset_words got=%h exp=0", words);
        end
        repeat (3) @(negedge clock);
        flags = {avm_read, avm_address, cpu_reset_req, check_done, id_ok, ts_ok, timeout_err};
        vectors++;
        if (flags !== 7'b0010000) begin
            miscompares++; $display("FAIL reset_hold_flags got=%b exp=%b", flags, 7'b0010000);
        end
    endtask

    task automatic test_zero_wait();
        int n; bit exp_d; res_t e, o; logic [3:0] pat;
        slave_init(EXP_ID, EXP_TS, 0, 0);
        sb.push_back(model(EXP_ID, EXP_TS));
        reset_n = 1'b1;   // still in reset from test_reset; released at this falling edge
        run_until_done(20, n, exp_d);
        vectors++;
        if (exp_d || n > 6) begin
            miscompares++; $display("FAIL zw_latency got=%0d cycles exp<=6", n);
        end
        pat = {rd_hist[0], rd_hist[1], rd_hist[2], rd_hist[3]};
        vectors++;
        if (pat !== 4'b1010) begin
            miscompares++; $display("FAIL zw_read_gap got=%b exp=1010", pat);
        end
        vectors++;
        if (cpu_reset_req !== 1'b0) begin
            miscompares++; $display("FAIL zw_release got=%b exp=0", cpu_reset_req);
        end
        e = sb.pop_front(); o = observed();
        vectors++;
        if (o !== e) begin
            miscompares++; $display("FAIL zw_result got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_mismatch_recheck();
        int n; bit exp_d; res_t e, o;
        slave_init(EXP_ID, EXP_TS + 32'd1, 0, 0);
        sb.push_back(model(EXP_ID, EXP_TS + 32'd1));
        do_reset();
        run_until_done(20, n, exp_d);
        vectors++;
        if (exp_d) begin
            miscompares++; $display("FAIL mm_done got=%b exp=1", check_done);
        end
        e = sb.pop_front(); o = observed();
        vectors++;
        if (o !== e) begin
            miscompares++; $display("FAIL mm_result got=%h exp=%h", o, e);
        end
        slv_data[1] = EXP_TS;
        sb.push_back(model(EXP_ID, EXP_TS));
        recheck = 1'b1;
        slave_cycle();
        recheck = 1'b0;
        vectors++;
        if ({check_done, cpu_reset_req, id_ok, ts_ok} !== 4'b0100) begin
            miscompares++;
            $display("FAIL mm_recheck_clear got=%b exp=0100", {check_done, cpu_reset_req, id_ok, ts_ok});
        end
        run_until_done(20, n, exp_d);
        e = sb.pop_front(); o = observed();
        vectors++;
        if (exp_d || o !== e) begin
            miscompares++; $display("FAIL mm_recheck_result got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_timeout();
        int n, bad; bit exp_d; res_t e, o;
        slave_init(EXP_ID, EXP_TS, BIG, 0);
        sb.push_back({32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1});
        do_reset();
        run_until_done(1200, n, exp_d);
        e = sb.pop_front(); o = observed();
        vectors++;
        if (exp_d || o !== e) begin
            miscompares++; $display("FAIL to_result got=%h exp=%h", o, e);
        end
        vectors++;
        if (attempts != 4) begin
            miscompares++; $display("FAIL to_attempts got=%0d exp=4", attempts);
        end
        bad = (len_q.size() == 4) ? 0 : 1;
        foreach (len_q[i]) if (len_q[i] != 256) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL to_attempt_len got=%p exp=4x256", len_q);
        end
        vectors++;
        if (avm_read !== 1'b0) begin
            miscompares++; $display("FAIL to_read_idle got=%b exp=0", avm_read);
        end
    endtask

    task automatic test_long_stall();
        int n; bit exp_d; res_t e, o;
        slave_init(EXP_ID, EXP_TS, 255, 0);
        sb.push_back(model(EXP_ID, EXP_TS));
        do_reset();
        run_until_done(400, n, exp_d);
        e = sb.pop_front(); o = observed();
        vectors++;
        if (exp_d || o !== e) begin
            miscompares++; $display("FAIL ls_result got=%h exp=%h", o, e);
        end
        vectors++;
        if (attempts != 2 || drops != 0) begin
            miscompares++; $display("FAIL ls_no_retry got=%0d/%0d exp=2/0 (attempts/drops)", attempts, drops);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++; $display("FAIL ls_stable got=%0d exp=0", unstable);
        end
        vectors++;
        if (len_q.size() < 1 || len_q[0] != 256) begin
            miscompares++; $display("FAIL ls_len got=%p exp=256 first", len_q);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit exp_d, seen; res_t e, o; logic [6:0] flags;
        slave_init(EXP_ID, EXP_TS, 0, BIG);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            slave_cycle();
            seen = avm_read && avm_address;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL rm_ts_stall got=%b exp=1", seen);
        end
        repeat (5) slave_cycle();
        #1 reset_n = 1'b0;
        #1;
        flags = {avm_read, avm_address, cpu_reset_req, check_done, id_ok, ts_ok, timeout_err};
        vectors++;
        if (flags !== 7'b0010000 || {id_value, ts_value} !== 64'h0) begin
            miscompares++; $display("FAIL rm_reset_vals got=%b exp=%b", flags, 7'b0010000);
        end
        @(negedge clock);
        slave_init(EXP_ID, EXP_TS, 0, 0);
        sb.push_back(model(EXP_ID, EXP_TS));
        reset_n = 1'b1;
        run_until_done(20, n, exp_d);
        vectors++;
        if (first_addr !== 1'b0) begin
            miscompares++; $display("FAIL rm_restart_addr got=%b exp=0", first_addr);
        end
        e = sb.pop_front(); o = observed();
        vectors++;
        if (exp_d || o !== e) begin
            miscompares++; $display("FAIL rm_result got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_recheck_ignored();
        int n; bit exp_d, seen; res_t e, o;
        slave_init(EXP_ID, EXP_TS, 0, 20);
        sb.push_back(model(EXP_ID, EXP_TS));
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            slave_cycle();
            seen = avm_read && avm_address;
        end
        recheck = 1'b1;
        slave_cycle();
        recheck = 1'b0;
        run_until_done(60, n, exp_d);
        e = sb.pop_front(); o = observed();
        vectors++;
        if (exp_d || o !== e) begin
            miscompares++; $display("FAIL ri_result got=%h exp=%h", o, e);
        end
        vectors++;
        if (attempts != 2) begin
            miscompares++; $display("FAIL ri_attempts got=%0d exp=2", attempts);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_mismatch_recheck();
        test_timeout();
        test_long_stall();
        test_reset_mid();
        test_recheck_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
